// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter through its tx_en/tx_data/tx_busy handshake.
// Producers push at up to one byte per cycle; frames are launched one at a time.
module uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  wr_en,
    input  logic [7:0]            wr_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    input  logic                  overflow_clear,
    output logic                  drained,
    output logic                  tx_en,
    output logic [7:0]            tx_data,
    input  logic                  tx_busy
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_LAUNCH    = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE = 2'd2;

    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = (DEPTH_LOG2)'(1'b1);
    localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2+1)'(1'b1);
    localparam logic [DEPTH_LOG2:0]   LVL_ZERO = (DEPTH_LOG2+1)'(1'b0);
    localparam logic [DEPTH_LOG2:0]   LVL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic                  overflow_q, overflow_d;
    logic [1:0]            state_q, state_d;
    logic [7:0]            tx_data_q, tx_data_d;

    logic full_s;
    logic empty_s;
    logic push_s;
    logic drop_s;
    logic pop_s;

    // Status is decoded from the registered level so a push is never poppable in its own cycle.
    assign full_s  = (level_q == LVL_FULL);
    assign empty_s = (level_q == LVL_ZERO);
    assign push_s  = wr_en && !full_s;
    assign drop_s  = wr_en && full_s;
    assign pop_s   = (state_q == ST_IDLE) && !empty_s && !tx_busy;

    // Storage array write port; contents need no reset since level gates every read.
    always_ff @(posedge sys_clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // Next-state for pointers, level, overflow flag, launch FSM and output byte.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        state_d    = state_q;
        tx_data_d  = tx_data_q;

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d  = rd_ptr_q + PTR_ONE;
            tx_data_d = mem_q[rd_ptr_q];
        end else begin
            rd_ptr_d  = rd_ptr_q;
            tx_data_d = tx_data_q;
        end

        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase

        // A dropped push outranks a simultaneous clear so no loss goes unreported.
        if (drop_s) begin
            overflow_d = 1'b1;
        end else if (overflow_clear) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (pop_s) begin
                    state_d = ST_LAUNCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                if (tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else begin
                    state_d = ST_LAUNCH;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with asynchronous clear.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            state_q    <= ST_IDLE;
            tx_data_q  <= 8'h00;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign full     = full_s;
    assign empty    = empty_s;
    assign level    = level_q;
    assign overflow = overflow_q;
    assign tx_en    = (state_q == ST_LAUNCH);
    assign tx_data  = tx_data_q;
    assign drained  = empty_s && (state_q == ST_IDLE) && !tx_busy;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: one task per scenario, transmitter handshake driven by hand.
module tb_uart_tx_fifo;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       empty;
    logic [4:0] level;
    logic       overflow;
    logic       overflow_clear;
    logic       drained;
    logic       tx_en;
    logic [7:0] tx_data;
    logic       tx_busy;

    int checks   = 0;
    int failures = 0;

    always #5 sys_clk = ~sys_clk;

    uart_tx_fifo #(.DEPTH_LOG2(4)) dut (
        .sys_clk        (sys_clk),
        .sys_rst_n      (sys_rst_n),
        .wr_en          (wr_en),
        .wr_data        (wr_data),
        .full           (full),
        .empty          (empty),
        .level          (level),
        .overflow       (overflow),
        .overflow_clear (overflow_clear),
        .drained        (drained),
        .tx_en          (tx_en),
        .tx_data        (tx_data),
        .tx_busy        (tx_busy)
    );

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    // Waits for tx_en, captures the byte, then plays a frame: busy after dly cycles for len cycles.
    task automatic serve_frame(input int dly, input int len, output logic [7:0] b,
                               output int waits, output bit ok);
        waits = 0;
        while (!tx_en && waits < 40) begin
            step();
            waits++;
        end
        ok = tx_en;
        b  = tx_data;
        if (ok) begin
            repeat (dly) step();
            tx_busy = 1'b1;
            repeat (len) step();
            tx_busy = 1'b0;
        end
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0; wr_en = 1'b0; wr_data = 8'h00;
        overflow_clear = 1'b0; tx_busy = 1'b0;
        #12;
        checks++;
        if ({tx_en, empty, full, level, overflow, tx_data, drained} !== {1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 8'h00, 1'b1}) begin
            failures++;
            $display("FAIL reset: tx_en=%b empty=%b full=%b level=%0d ovf=%b data=%h drained=%b, required 0 1 0 0 0 00 1",
                     tx_en, empty, full, level, overflow, tx_data, drained);
        end
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_byte();
        wr_en = 1'b1; wr_data = 8'h55;
        step();
        wr_en = 1'b0;
        checks++;
        if (level !== 5'd1 || tx_en !== 1'b0) begin
            failures++;
            $display("FAIL single_n1: level=%0d tx_en=%b, required 1 0", level, tx_en);
        end
        step();
        checks++;
        if (tx_en !== 1'b1 || tx_data !== 8'h55 || level !== 5'd0) begin
            failures++;
            $display("FAIL single_launch: tx_en=%b data=%h level=%0d, required 1 55 0", tx_en, tx_data, level);
        end
        step(); step(); step();
        checks++;
        if (tx_en !== 1'b1 || tx_data !== 8'h55) begin
            failures++;
            $display("FAIL single_hold: tx_en=%b data=%h, required 1 55", tx_en, tx_data);
        end
        tx_busy = 1'b1;
        step();
        checks++;
        if (tx_en !== 1'b0 || drained !== 1'b0 || tx_data !== 8'h55) begin
            failures++;
            $display("FAIL single_busy: tx_en=%b drained=%b data=%h, required 0 0 55", tx_en, drained, tx_data);
        end
        step(); step();
        tx_busy = 1'b0;
        step();
        checks++;
        if (drained !== 1'b1 || empty !== 1'b1) begin
            failures++;
            $display("FAIL single_drained: drained=%b empty=%b, required 1 1", drained, empty);
        end
    endtask

    task automatic test_burst_overflow();
        logic [7:0] b;
        int         waits;
        bit         ok;
        tx_busy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            step();
        end
        checks++;
        if (full !== 1'b1 || level !== 5'd16 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL burst_full: full=%b level=%0d ovf=%b, required 1 16 0", full, level, overflow);
        end
        wr_data = 8'hAA; overflow_clear = 1'b1;
        step();
        wr_en = 1'b0;
        checks++;
        if (overflow !== 1'b1 || level !== 5'd16) begin
            failures++;
            $display("FAIL overflow_set: ovf=%b level=%0d, required 1 16", overflow, level);
        end
        step();
        overflow_clear = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL overflow_clear: ovf=%b, required 0", overflow);
        end
        tx_busy = 1'b0;
        for (int i = 0; i < 16; i++) begin
            serve_frame(1, 2, b, waits, ok);
            checks++;
            if (!ok || b !== 8'(i) || (i > 0 && waits != 2)) begin
                failures++;
                $display("FAIL burst_order[%0d]: ok=%b byte=%h waits=%0d, required 1 %h 2", i, ok, b, waits, 8'(i));
            end
        end
        ok = 1'b0;
        repeat (6) begin
            step();
            if (tx_en) ok = 1'b1;
        end
        checks++;
        if (ok || drained !== 1'b1) begin
            failures++;
            $display("FAIL burst_no_extra: extra_launch=%b drained=%b, required 0 1", ok, drained);
        end
    endtask

    task automatic test_push_pop_wrap();
        logic [7:0] b;
        int         waits;
        bit         ok;
        tx_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_data = 8'h60 + 8'(i);
            step();
        end
        wr_data = 8'h65; tx_busy = 1'b0;
        step();
        wr_en = 1'b0;
        checks++;
        if (level !== 5'd5) begin
            failures++;
            $display("FAIL push_pop_level: level=%0d, required 5", level);
        end
        for (int i = 0; i < 6; i++) begin
            serve_frame(0, 1, b, waits, ok);
            checks++;
            if (!ok || b !== 8'h60 + 8'(i)) begin
                failures++;
                $display("FAIL push_pop_order[%0d]: ok=%b byte=%h, required 1 %h", i, ok, b, 8'h60 + 8'(i));
            end
        end
        step(); step();
        // 3 batches of 14 bytes walk both pointers across the wrap point.
        for (int k = 0; k < 3; k++) begin
            tx_busy = 1'b1;
            for (int i = 0; i < 14; i++) begin
                wr_en = 1'b1; wr_data = 8'((k * 14 + i) * 7 + 3);
                step();
            end
            wr_en = 1'b0; tx_busy = 1'b0;
            for (int i = 0; i < 14; i++) begin
                serve_frame(0, 1, b, waits, ok);
                checks++;
                if (!ok || b !== 8'((k * 14 + i) * 7 + 3)) begin
                    failures++;
                    $display("FAIL wrap_order[%0d]: ok=%b byte=%h, required 1 %h", k * 14 + i, ok, b,
                             8'((k * 14 + i) * 7 + 3));
                end
            end
            step(); step();
        end
        checks++;
        if (drained !== 1'b1 || level !== 5'd0) begin
            failures++;
            $display("FAIL wrap_end: drained=%b level=%0d, required 1 0", drained, level);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        tx_busy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_data = 8'h90 + 8'(i);
            step();
        end
        wr_en = 1'b0; tx_busy = 1'b0;
        step(); step();
        checks++;
        if (tx_en !== 1'b1 || level !== 5'd7 || tx_data !== 8'h90) begin
            failures++;
            $display("FAIL mid_setup: tx_en=%b level=%0d data=%h, required 1 7 90", tx_en, level, tx_data);
        end
        sys_rst_n = 1'b0;
        #1;
        checks++;
        if (tx_en !== 1'b0 || empty !== 1'b1 || level !== 5'd0 || tx_data !== 8'h00) begin
            failures++;
            $display("FAIL mid_reset: tx_en=%b empty=%b level=%0d data=%h, required 0 1 0 00",
                     tx_en, empty, level, tx_data);
        end
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            step();
            if (tx_en) seen = 1'b1;
        end
        checks++;
        if (seen || drained !== 1'b1) begin
            failures++;
            $display("FAIL mid_after: launch_seen=%b drained=%b, required 0 1", seen, drained);
        end
    endtask

    task automatic test_slow_handshake();
        logic [7:0] b;
        int         waits;
        bit         ok;
        bit         bad;
        tx_busy = 1'b1;
        wr_en = 1'b1; wr_data = 8'h3C;
        step();
        wr_data = 8'h3D;
        step();
        wr_en = 1'b0; tx_busy = 1'b0;
        step(); step();
        bad = 1'b0;
        repeat (20) begin
            if (tx_en !== 1'b1 || tx_data !== 8'h3C || level !== 5'd1) bad = 1'b1;
            step();
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL slow_hold: tx_en/tx_data/level not held at 1/3c/1, now %b %h %0d", tx_en, tx_data, level);
        end
        tx_busy = 1'b1;
        step();
        tx_busy = 1'b0;
        serve_frame(0, 1, b, waits, ok);
        checks++;
        if (!ok || b !== 8'h3D) begin
            failures++;
            $display("FAIL slow_second: ok=%b byte=%h, required 1 3d", ok, b);
        end
        step(); step();
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_burst_overflow();
        test_push_pop_wrap();
        test_reset_mid();
        test_slow_handshake();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
